conv_win_sched: RTL and testbench

- Frame sequencer for the 5x5 convolution datapath.
- Accepts a raster pixel stream, tracks input and window-centre coordinates, and drives line-buffer/window shift enables.
- Emits one kernel_pos_t edge mask per output pixel, marking which neighbours fall outside the image.
- Sits between the pixel ingress and the line-buffer/MAC array; handles frame start, pipeline fill, and the end-of-frame flush.

---
 rtl/conv_win_sched.sv | 211 +++++++++++++++++++++
 tb/tb_conv_win_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_win_sched.sv
// conv_win_sched: raster frame sequencer for the 5x5 convolution window (fill, run, flush).
// Optional stall counters are compiled in when CONV_WIN_SCHED_PERF_EN is defined.
module conv_win_sched #(
  parameter int IMAGE_MAX_W       = 4096,
  parameter int IMAGE_MAX_H       = 4096,
  parameter int KERNEL_DIAMETER_N = 5,
  parameter int DIM_W             = $clog2(IMAGE_MAX_W) + 1,
  localparam int KERNEL_POS_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [DIM_W-1:0]        cfg_w,
  input  logic [DIM_W-1:0]        cfg_h,
  output logic                    cfg_err,
  output logic                    busy,
  output logic                    done,
  input  logic                    i_vld,
  output logic                    i_rdy,
  output logic                    lb_shift,
  output logic                    lb_bubble,
  output logic                    o_vld,
  input  logic                    o_rdy,
  output logic [KERNEL_POS_W-1:0] o_pos,
  output logic [DIM_W-1:0]        o_x,
  output logic [DIM_W-1:0]        o_y,
  output logic                    o_sof,
  output logic                    o_eol
`ifdef CONV_WIN_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_in_stall,
  output logic [31:0]             perf_out_stall
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

  // Bit set = that neighbour of the window centre lies outside the image.
  typedef struct packed {
    logic w2; logic w1; logic e2; logic e1;
    logic n2; logic n1; logic s2; logic s1;
  } kernel_pos_t;

  localparam logic [DIM_W-1:0] RAD = DIM_W'(KERNEL_DIAMETER_N / 2);

  state_t           state_r, state_nx_s;
  logic [DIM_W-1:0] w_r, h_r, ix_r, iy_r, cx_r, cy_r, o_x_r, o_y_r;
  kernel_pos_t      pos_s, o_pos_r;
  logic             o_vld_r, o_sof_r, o_eol_r, busy_r, done_r, cfg_err_r, flushed_r;
  logic             cfg_ok_s, start_acc_s, out_free_s, step_s, bubble_s, i_rdy_s;
  logic             out_step_s, fill_last_s, in_last_s, c_last_col_s, c_last_s;

  assign cfg_ok_s     = (cfg_w >= DIM_W'(3)) && (cfg_w <= DIM_W'(IMAGE_MAX_W)) &&
                        (cfg_h >= DIM_W'(3)) && (cfg_h <= DIM_W'(IMAGE_MAX_H));
  assign start_acc_s  = (state_r == S_IDLE) && cfg_start && cfg_ok_s;
  assign out_free_s   = o_rdy || !o_vld_r;
  // The fill ends on input index 2W+1, i.e. row RAD, column RAD-1.
  assign fill_last_s  = (iy_r == RAD) && (ix_r == RAD - DIM_W'(1));
  assign in_last_s    = (iy_r == h_r - DIM_W'(1)) && (ix_r == w_r - DIM_W'(1));
  assign c_last_col_s = (cx_r == w_r - DIM_W'(1));
  assign c_last_s     = c_last_col_s && (cy_r == h_r - DIM_W'(1));
  assign out_step_s   = step_s && ((state_r == S_RUN) || (state_r == S_FLUSH));

  // Next-state and handshake decode.
  always_comb begin
    state_nx_s = state_r;
    i_rdy_s    = 1'b0;
    step_s     = 1'b0;
    bubble_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_acc_s) state_nx_s = S_FILL;
        else             state_nx_s = S_IDLE;
      end
      S_FILL: begin
        i_rdy_s = 1'b1;
        step_s  = i_vld;
        if (step_s && fill_last_s) state_nx_s = S_RUN;
        else                       state_nx_s = S_FILL;
      end
      S_RUN: begin
        i_rdy_s = out_free_s;
        step_s  = i_vld && out_free_s;
        if (step_s && in_last_s) state_nx_s = S_FLUSH;
        else                     state_nx_s = S_RUN;
      end
      S_FLUSH: begin
        step_s   = out_free_s && !flushed_r;
        bubble_s = step_s;
        if (flushed_r && o_vld_r && o_rdy) state_nx_s = S_DONE;
        else                               state_nx_s = S_FLUSH;
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Edge mask of the current centre.
  always_comb begin
    pos_s    = '0;
    pos_s.w2 = cx_r < DIM_W'(2);
    pos_s.w1 = cx_r < DIM_W'(1);
    pos_s.e2 = cx_r > (w_r - DIM_W'(3));
    pos_s.e1 = cx_r > (w_r - DIM_W'(2));
    pos_s.n2 = cy_r < DIM_W'(2);
    pos_s.n1 = cy_r < DIM_W'(1);
    pos_s.s2 = cy_r > (h_r - DIM_W'(3));
    pos_s.s1 = cy_r > (h_r - DIM_W'(2));
  end

  // State register, latched frame size and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      w_r       <= '0;
      h_r       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cfg_err_r <= (state_r == S_IDLE) && cfg_start && !cfg_ok_s;
      done_r    <= (state_r == S_FLUSH) && (state_nx_s == S_DONE);
      busy_r    <= start_acc_s || (busy_r && (state_nx_s != S_DONE));
      if (start_acc_s) begin
        w_r <= cfg_w;
        h_r <= cfg_h;
      end
    end
  end

  // Input raster counter, advanced by every consumed pixel.
  always_ff @(posedge clk) begin
    if (!rst_n || start_acc_s) begin
      ix_r <= '0;
      iy_r <= '0;
    end else if (step_s && !bubble_s) begin
      if (ix_r == w_r - DIM_W'(1)) begin
        ix_r <= '0;
        iy_r <= iy_r + DIM_W'(1);
      end else begin
        ix_r <= ix_r + DIM_W'(1);
      end
    end
  end

  // Centre counter and the registered output slot (held while stalled).
  always_ff @(posedge clk) begin
    if (!rst_n || start_acc_s) begin
      cx_r      <= '0;
      cy_r      <= '0;
      flushed_r <= 1'b0;
      o_vld_r   <= 1'b0;
      o_x_r     <= '0;
      o_y_r     <= '0;
      o_pos_r   <= '0;
      o_sof_r   <= 1'b0;
      o_eol_r   <= 1'b0;
    end else if (out_step_s) begin
      o_vld_r <= 1'b1;
      o_x_r   <= cx_r;
      o_y_r   <= cy_r;
      o_pos_r <= pos_s;
      o_sof_r <= (cx_r == DIM_W'(0)) && (cy_r == DIM_W'(0));
      o_eol_r <= c_last_col_s;
      if (c_last_s) flushed_r <= 1'b1;
      if (c_last_col_s) begin
        cx_r <= '0;
        cy_r <= cy_r + DIM_W'(1);
      end else begin
        cx_r <= cx_r + DIM_W'(1);
      end
    end else if (o_rdy) begin
      o_vld_r <= 1'b0;
    end
  end

  assign cfg_err   = cfg_err_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign i_rdy     = i_rdy_s;
  assign lb_shift  = step_s;
  assign lb_bubble = bubble_s;
  assign o_vld     = o_vld_r;
  assign o_pos     = o_pos_r;
  assign o_x       = o_x_r;
  assign o_y       = o_y_r;
  assign o_sof     = o_sof_r;
  assign o_eol     = o_eol_r;

`ifdef CONV_WIN_SCHED_PERF_EN
  logic [31:0] perf_in_r, perf_out_r;

  // Saturating stall counters, cleared when a frame is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n || start_acc_s) begin
      perf_in_r  <= '0;
      perf_out_r <= '0;
    end else begin
      if (busy_r && !i_vld && i_rdy_s && (perf_in_r != 32'hFFFF_FFFF))
        perf_in_r <= perf_in_r + 32'd1;
      if (o_vld_r && !o_rdy && (perf_out_r != 32'hFFFF_FFFF))
        perf_out_r <= perf_out_r + 32'd1;
    end
  end

  assign perf_in_stall  = perf_in_r;
  assign perf_out_stall = perf_out_r;
`endif

endmodule

// File: tb/tb_conv_win_sched.sv
// Self-checking bench for conv_win_sched: config table, frame scoreboard, corner sequences.
// Perf counter checks compile in with CONV_WIN_SCHED_PERF_EN.
module tb_conv_win_sched;

  logic        clk, rst_n, cfg_start, cfg_err, busy, done;
  logic [12:0] cfg_w, cfg_h, o_x, o_y;
  logic        i_vld, i_rdy, lb_shift, lb_bubble, o_vld, o_rdy, o_sof, o_eol;
  logic [7:0]  o_pos;
`ifdef CONV_WIN_SCHED_PERF_EN
  logic [31:0] perf_in_stall, perf_out_stall;
`endif

  conv_win_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_err(cfg_err), .busy(busy), .done(done), .i_vld(i_vld), .i_rdy(i_rdy),
    .lb_shift(lb_shift), .lb_bubble(lb_bubble), .o_vld(o_vld), .o_rdy(o_rdy),
    .o_pos(o_pos), .o_x(o_x), .o_y(o_y), .o_sof(o_sof), .o_eol(o_eol)
`ifdef CONV_WIN_SCHED_PERF_EN
    , .perf_in_stall(perf_in_stall), .perf_out_stall(perf_out_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame model state shared between the driver and the negedge monitor.
  int   fw, fh, total, n_in, n_out, n_bub, step_cnt, done_cnt, cyc;
  int   first_acc, first_vld, last_acc, done_cyc, last_x, last_y;
  logic mon_en, done_seen, seen_max, prev_stall, last_eol;
  logic [35:0] held;
  logic [7:0]  got_pos [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Neighbour at distance d is outside when the coordinate is within d of an edge.
  function automatic logic [7:0] exp_pos(input int x, input int y, input int w, input int h);
    return {x < 2, x < 1, x > w - 3, x > w - 2, y < 2, y < 1, y > h - 3, y > h - 2};
  endfunction

  task automatic chk_reset(input string name);
    chk(name, 64'({busy, done, cfg_err, i_rdy, lb_shift, lb_bubble, o_vld, o_sof, o_eol,
                   o_pos, o_x, o_y}), 64'd0);
  endtask

  initial begin
    int ex, ey;
    cyc = 0; mon_en = 1'b0; prev_stall = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        chk("in_hs", 64'(lb_shift && !lb_bubble), 64'(i_vld && i_rdy));
        if (lb_bubble) begin
          chk("bub_shift", 64'(lb_shift), 64'd1);
          chk("bub_early", 64'(n_in), 64'(total));
        end
        if (n_in == total) chk("rdy_flush", 64'(i_rdy), 64'd0);
        if (o_vld && !o_rdy) chk("rdy_stall", 64'(i_rdy), 64'd0);
        if (prev_stall) chk("hold", 64'({o_vld, o_x, o_y, o_pos, o_sof, o_eol}), 64'({1'b1, held}));
        chk("busy", 64'(busy), 64'(!done));
        if (o_vld && first_vld < 0) first_vld = cyc;
        if (o_vld && o_rdy) begin
          if (n_out < total) begin
            ex = n_out % fw;
            ey = n_out / fw;
            chk("out", 64'({o_x, o_y, o_pos, o_sof, o_eol}),
                64'({13'(ex), 13'(ey), exp_pos(ex, ey, fw, fh), (ex == 0) && (ey == 0), ex == fw - 1}));
            chk("lat", 64'(step_cnt >= n_out + 2 * fw + 3), 64'd1);
            if (n_out < 64) got_pos[n_out] = o_pos;
            if (o_x == 13'd4095 && o_pos[5:4] == 2'b11 && o_eol) seen_max = 1'b1;
          end else begin
            chk("extra_out", 64'(n_out + 1), 64'(total));
          end
          last_x = int'(o_x); last_y = int'(o_y); last_eol = o_eol;
          n_out++;
          last_acc = cyc;
        end
        if (done) begin
          chk("done_cnt", 64'(n_out), 64'(total));
          chk("done_time", 64'(cyc), 64'(last_acc + 1));
          done_seen = 1'b1; done_cnt++; done_cyc = cyc;
        end
        if (lb_shift && !lb_bubble) begin
          n_in++;
          if (first_acc < 0) first_acc = cyc;
        end
        if (lb_bubble) n_bub++;
        if (lb_shift) step_cnt++;
        prev_stall = o_vld && !o_rdy;
        held = {o_x, o_y, o_pos, o_sof, o_eol};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // rdy_mode: 0..100 = percent ready, above 100 = alternate 1/0 each cycle.
  task automatic run_frame(input int w, input int h, input int vld_pct, input int rdy_mode,
                           input int abort_at);
    int budget;
    fw = w; fh = h; total = w * h; n_in = 0; n_out = 0; n_bub = 0; step_cnt = 0;
    done_cnt = 0; done_seen = 1'b0; seen_max = 1'b0; first_acc = -1; first_vld = -1;
    last_acc = -1; done_cyc = -1;
    @(posedge clk); #1;
    cfg_w = 13'(w); cfg_h = 13'(h); cfg_start = 1'b1; i_vld = 1'b0; o_rdy = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("start_busy", 64'({busy, cfg_err}), 64'(2'b10));
    mon_en = 1'b1;
    budget = w * h * 20 + 200;
    while (!done_seen && budget > 0) begin
      if (abort_at >= 0 && n_out >= abort_at) break;
      i_vld = (n_in < total) && (int'($urandom_range(99)) < vld_pct);
      if (rdy_mode > 100) o_rdy = !o_rdy;
      else                o_rdy = int'($urandom_range(99)) < rdy_mode;
      @(posedge clk); #1;
      budget--;
    end
    mon_en = 1'b0; i_vld = 1'b0; o_rdy = 1'b0;
    if (abort_at < 0) begin
      chk("timeout", 64'(done_seen), 64'd1);
      chk("n_out", 64'(n_out), 64'(total));
      chk("n_in", 64'(n_in), 64'(total));
      chk("n_bub", 64'(n_bub), 64'(2 * w + 2));
      chk("done_once", 64'(done_cnt), 64'd1);
      if (vld_pct == 100 && rdy_mode == 100) begin
        chk("first_lat", 64'(first_vld - first_acc), 64'(2 * w + 3));
        chk("thruput", 64'(done_cyc - first_acc), 64'(total + 2 * w + 3));
      end
    end
  endtask

  typedef struct {
    logic [12:0] w;
    logic [12:0] h;
    logic        exp_err;
    logic        exp_busy;
  } cfg_vec_t;

  cfg_vec_t cfg_tab [9];

  initial begin
    logic bad;
    cfg_tab[0] = '{13'd2,    13'd3,    1'b1, 1'b0};
    cfg_tab[1] = '{13'd3,    13'd2,    1'b1, 1'b0};
    cfg_tab[2] = '{13'd0,    13'd5,    1'b1, 1'b0};
    cfg_tab[3] = '{13'd4097, 13'd4,    1'b1, 1'b0};
    cfg_tab[4] = '{13'd3,    13'd4097, 1'b1, 1'b0};
    cfg_tab[5] = '{13'd8191, 13'd8191, 1'b1, 1'b0};
    cfg_tab[6] = '{13'd3,    13'd3,    1'b0, 1'b1};
    cfg_tab[7] = '{13'd4096, 13'd4096, 1'b0, 1'b1};
    cfg_tab[8] = '{13'd100,  13'd7,    1'b0, 1'b1};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_w = '0; cfg_h = '0; i_vld = 1'b0; o_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      cfg_w = cfg_tab[i].w; cfg_h = cfg_tab[i].h; cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      chk($sformatf("cfg%0d", i), 64'({cfg_err, busy}), 64'({cfg_tab[i].exp_err, cfg_tab[i].exp_busy}));
      @(posedge clk); #1;
      chk($sformatf("cfg%0d_pulse", i), 64'({cfg_err, busy}), 64'({1'b0, cfg_tab[i].exp_busy}));
      if (cfg_tab[i].exp_busy) begin
        cfg_w = 13'd2; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk($sformatf("cfg%0d_ignored", i), 64'({cfg_err, busy}), 64'(2'b01));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset($sformatf("cfg%0d_abort", i));
        rst_n = 1'b1;
      end
    end

    run_frame(4, 3, 100, 100, -1);
    chk("pos_first", 64'(got_pos[0]), 64'(8'hCC));
    chk("pos_3_2", 64'(got_pos[11]), 64'(8'h33));

    // In a 3x3 image the centre sees only its distance-2 neighbours fall outside.
    run_frame(3, 3, 100, 100, -1);
    chk("pos_centre", 64'(got_pos[4]), 64'(8'hAA));

    run_frame(8, 8, 100, 101, -1);

    run_frame(5, 4, 100, 100, -1);
    chk("last_out", 64'({13'(last_x), 13'(last_y), last_eol}), 64'({13'd4, 13'd3, 1'b1}));

    run_frame(16, 16, 100, 100, 7);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset("abort_rst");
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1'b1;
    end
    chk("abort_quiet", 64'(bad), 64'd0);
    run_frame(4, 4, 100, 100, -1);

    for (int r = 0; r < 4; r++)
      run_frame(int'($urandom_range(3, 9)), int'($urandom_range(3, 9)),
                int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), -1);

    run_frame(4096, 4, 100, 100, -1);
    chk("max_corner", 64'(seen_max), 64'd1);

`ifdef CONV_WIN_SCHED_PERF_EN
    @(posedge clk); #1;
    cfg_w = 13'd3; cfg_h = 13'd3; cfg_start = 1'b1; i_vld = 1'b0; o_rdy = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("perf_in", 64'(perf_in_stall), 64'd5);
    chk("perf_out0", 64'(perf_out_stall), 64'd0);
    i_vld = 1'b1;
    for (int k = 0; k < 100 && !o_vld; k++) begin
      @(posedge clk); #1;
    end
    chk("perf_vld", 64'(o_vld), 64'd1);
    repeat (100) @(posedge clk);
    #1;
    chk("perf_out", 64'(perf_out_stall), 64'd100);
    chk("perf_in_hold", 64'(perf_in_stall), 64'd5);
    rst_n = 1'b0; i_vld = 1'b0;
    @(posedge clk); #1;
    chk("perf_rst", 64'({perf_in_stall, perf_out_stall}), 64'd0);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
